// File: rtl/hu_pipe_ctrl_if.sv
// Hazard-unit memory handshake: instruction/data busy flags in, request
// strobes and replay-buffer select out. Shared stage-control types live in
// the package so the pipeline registers and the bench agree on encodings.

package hu_pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      ENABLE = 2'b00,
      STALL  = 2'b01,
      FLUSH  = 2'b10
   } HAZARD_ctrl;

   typedef enum logic {
      NEXT = 1'b0,
      JUMP = 1'b1
   } IF_ctrl;
endpackage

interface hu_pipe_ctrl_if;
   logic INSTR_mem_busy_in;
   logic DATA_mem_busy_in;
   logic HZ_instr_req;
   logic HZ_data_req;
   logic instr_mux_sel;

   modport master (
      input  INSTR_mem_busy_in,
      input  DATA_mem_busy_in,
      output HZ_instr_req,
      output HZ_data_req,
      output instr_mux_sel
   );

   modport slave (
      output INSTR_mem_busy_in,
      output DATA_mem_busy_in,
      input  HZ_instr_req,
      input  HZ_data_req,
      input  instr_mux_sel
   );
endinterface

// File: rtl/hu_pipe_ctrl.sv
// Pipeline hazard unit for the 5-stage core: RAW detection, operand
// forwarding selects, memory wait-state FSM with replay and timeout, and a
// saturating stall counter.
// Build option: define HU_FWD_EN to enable EX/MEM and MEM/WB forwarding;
// without it every valid RAW match stalls the front end.

module hu_pipe_ctrl
   import hu_pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int TIMEOUT_CYC = 1024,
   parameter int PERF_W      = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   hu_pipe_ctrl_if.master    mem,
   input  IF_ctrl            BRANCH_cond_in,
   input  logic [REG_AW-1:0] EX_MEM_RD_in,
   input  logic              EX_MEM_we_rd_in,
   input  logic              EX_MEM_is_load_in,
   input  logic [REG_AW-1:0] MEM_WB_RD_in,
   input  logic              MEM_WB_we_rd_in,
   input  logic [REG_AW-1:0] DEC_EX_RS1_in,
   input  logic [REG_AW-1:0] DEC_EX_RS2_in,
   input  logic              DEC_EX_use_rs1_in,
   input  logic              DEC_EX_use_rs2_in,
   output HAZARD_ctrl        PC_REG_out,
   output HAZARD_ctrl        IF_DEC_out,
   output HAZARD_ctrl        DEC_EX_out,
   output HAZARD_ctrl        EX_MEM_out,
   output HAZARD_ctrl        MEM_WB_out,
   output logic [1:0]        FWD_A_sel,
   output logic [1:0]        FWD_B_sel,
   output logic              HZ_timeout_err,
   output logic [PERF_W-1:0] HZ_stall_cnt
);

   typedef enum logic [2:0] {
      ST_RUN, ST_WAIT_I, ST_WAIT_D, ST_WAIT_B, ST_REPLAY, ST_ERROR
   } state_t;

   localparam int WCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   logic              ib, db, in_wait, nxt_wait, tmo_hit;
   logic              ex_ok, wb_ok, m1_ex, m2_ex, m1_wb, m2_wb, ld_use, hz_stall;
   logic [1:0]        fwd_a_c, fwd_b_c;

   assign ib       = mem.INSTR_mem_busy_in;
   assign db       = mem.DATA_mem_busy_in;
   assign in_wait  = state inside {ST_WAIT_I, ST_WAIT_D, ST_WAIT_B};
   assign nxt_wait = state_nxt inside {ST_WAIT_I, ST_WAIT_D, ST_WAIT_B};
   assign tmo_hit  = (TIMEOUT_CYC != 0) && (wait_cnt == TMO_LAST);

   // A producer only counts if it really writes a non-x0 register that a used source reads.
   assign ex_ok  = EX_MEM_we_rd_in && (EX_MEM_RD_in != '0);
   assign wb_ok  = MEM_WB_we_rd_in && (MEM_WB_RD_in != '0);
   assign m1_ex  = ex_ok && DEC_EX_use_rs1_in && (DEC_EX_RS1_in == EX_MEM_RD_in);
   assign m2_ex  = ex_ok && DEC_EX_use_rs2_in && (DEC_EX_RS2_in == EX_MEM_RD_in);
   assign m1_wb  = wb_ok && DEC_EX_use_rs1_in && (DEC_EX_RS1_in == MEM_WB_RD_in);
   assign m2_wb  = wb_ok && DEC_EX_use_rs2_in && (DEC_EX_RS2_in == MEM_WB_RD_in);
   assign ld_use = EX_MEM_is_load_in && (m1_ex || m2_ex);

`ifdef HU_FWD_EN
   // Load data is not available in EX/MEM, so only non-load results forward from there.
   assign hz_stall = ld_use;
   assign fwd_a_c  = (m1_ex && !EX_MEM_is_load_in) ? 2'b01 : (m1_wb ? 2'b10 : 2'b00);
   assign fwd_b_c  = (m2_ex && !EX_MEM_is_load_in) ? 2'b01 : (m2_wb ? 2'b10 : 2'b00);
`else
   // No bypass paths: any in-flight producer of a used source holds the front end.
   assign hz_stall = ld_use || m1_ex || m2_ex || m1_wb || m2_wb;
   assign fwd_a_c  = 2'b00;
   assign fwd_b_c  = 2'b00;
`endif

   // State register; EN low freezes the FSM where it is.
   always_ff @(posedge CLK) begin
      if (RST)     state <= ST_RUN;
      else if (EN) state <= state_nxt;
   end

   // Next state: busy flags pick the wait flavour, the timeout overrides any still-busy wait.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (ib && db) state_nxt = ST_WAIT_B;
            else if (ib)  state_nxt = ST_WAIT_I;
            else if (db)  state_nxt = ST_WAIT_D;
         end
         ST_WAIT_B: begin
            if ((ib || db) && tmo_hit) state_nxt = ST_ERROR;
            else if (ib && db)         state_nxt = ST_WAIT_B;
            else if (ib)               state_nxt = ST_WAIT_I;
            else if (db)               state_nxt = ST_WAIT_D;
            else                       state_nxt = ST_REPLAY;
         end
         ST_WAIT_I: begin
            if (!ib)         state_nxt = ST_REPLAY;
            else if (tmo_hit) state_nxt = ST_ERROR;
         end
         ST_WAIT_D: begin
            if (!db)         state_nxt = ST_REPLAY;
            else if (tmo_hit) state_nxt = ST_ERROR;
         end
         ST_REPLAY: state_nxt = ST_RUN;
         ST_ERROR:  state_nxt = ST_ERROR;
         default:   state_nxt = ST_RUN;
      endcase
   end

   // Stage controls, strobes and forwarding selects from current state and hazard inputs.
   always_comb begin
      mem.HZ_instr_req  = 1'b0;
      mem.HZ_data_req   = 1'b0;
      mem.instr_mux_sel = 1'b0;
      PC_REG_out = STALL;
      IF_DEC_out = STALL;
      DEC_EX_out = STALL;
      EX_MEM_out = STALL;
      MEM_WB_out = STALL;
      FWD_A_sel  = 2'b00;
      FWD_B_sel  = 2'b00;
      if (RST) begin
         PC_REG_out = FLUSH;
         IF_DEC_out = FLUSH;
         DEC_EX_out = FLUSH;
         EX_MEM_out = FLUSH;
         MEM_WB_out = FLUSH;
      end else if (!EN) begin
         // Pipeline frozen; keep the replay buffer selected if we froze mid-replay.
         mem.instr_mux_sel = (state == ST_REPLAY);
      end else begin
         case (state)
            ST_RUN: begin
               mem.HZ_instr_req = 1'b1;
               mem.HZ_data_req  = 1'b1;
               FWD_A_sel  = fwd_a_c;
               FWD_B_sel  = fwd_b_c;
               EX_MEM_out = ENABLE;
               MEM_WB_out = ENABLE;
               if (hz_stall) begin
                  DEC_EX_out = FLUSH;
               end else if (BRANCH_cond_in == JUMP) begin
                  IF_DEC_out = FLUSH;
                  DEC_EX_out = ENABLE;
               end else begin
                  PC_REG_out = ENABLE;
                  IF_DEC_out = ENABLE;
                  DEC_EX_out = ENABLE;
               end
            end
            ST_REPLAY: begin
               mem.instr_mux_sel = 1'b1;
               FWD_A_sel  = fwd_a_c;
               FWD_B_sel  = fwd_b_c;
               PC_REG_out = ENABLE;
               IF_DEC_out = ENABLE;
               DEC_EX_out = ENABLE;
               EX_MEM_out = ENABLE;
               MEM_WB_out = ENABLE;
            end
            default: ;
         endcase
      end
   end

   // Consecutive wait cycles across all WAIT_* states; cleared once the FSM leaves them.
   always_ff @(posedge CLK) begin
      if (RST)     wait_cnt <= '0;
      else if (EN) wait_cnt <= (in_wait && nxt_wait) ? wait_cnt + 1'b1 : '0;
   end

   // Sticky timeout flag, only reset clears it.
   always_ff @(posedge CLK) begin
      if (RST)                               HZ_timeout_err <= 1'b0;
      else if (EN && state_nxt == ST_ERROR)  HZ_timeout_err <= 1'b1;
   end

   // Saturating count of enabled cycles in which the PC did not advance.
   always_ff @(posedge CLK) begin
      if (RST)
         HZ_stall_cnt <= '0;
      else if (EN && (PC_REG_out != ENABLE) && (HZ_stall_cnt != '1))
         HZ_stall_cnt <= HZ_stall_cnt + 1'b1;
   end

endmodule
